// File: rtl/strela_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// strela_ctrl_pkg - state encoding and defaults for the STRELA exec controller
// Revision: 1.0
// ============================================================================
package strela_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_LOAD_CFG = 2'd2,
    ST_EXEC     = 2'd3
  } state_t;

  localparam int DEFAULT_CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/strela_sat_counter.sv
`default_nettype none
// ============================================================================
// strela_sat_counter - up counter with synchronous clear that sticks at all-ones
// Revision: 1.0
// ============================================================================
module strela_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/strela_exec_ctrl.sv
`default_nettype none
// ============================================================================
// strela_exec_ctrl - sequences CSR command pulses into CGRA load/exec/clear phases
// Revision: 1.0
// ============================================================================
module strela_exec_ctrl
  import strela_ctrl_pkg::*;
#(
  parameter int OUTPUT_NODES_NUM = 4,
  parameter int CLEAR_CYCLES     = 2,
  parameter int CNT_W            = DEFAULT_CNT_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_configuration_i,
  input  logic                        start_execution_i,
  input  logic                        clear_cgra_config_i,
  input  logic                        clear_cgra_state_i,
  input  logic                        abort_i,
  input  logic [OUTPUT_NODES_NUM-1:0] out_active_i,
  input  logic                        cfg_done_i,
  input  logic [OUTPUT_NODES_NUM-1:0] out_done_i,
  input  logic                        stall_i,
  output logic                        cfg_start_o,
  output logic                        stream_start_o,
  output logic                        flush_o,
  output logic                        cgra_en_o,
  output logic                        cgra_clear_config_o,
  output logic                        cgra_clear_state_o,
  output logic                        busy_o,
  output logic                        done_config_o,
  output logic                        done_exec_o,
  output logic                        error_o,
  output logic                        irq_o,
  output logic [CNT_W-1:0]            cycle_count_load_config_o,
  output logic [CNT_W-1:0]            cycle_count_execute_o,
  output logic [CNT_W-1:0]            cycle_count_stall_o
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  state_t                      state;
  logic                        pending;
  logic [OUTPUT_NODES_NUM-1:0] mask;
  logic [OUTPUT_NODES_NUM-1:0] collected;
  logic [CLR_W-1:0]            clr_cnt;

  logic                        clear_req;
  logic                        any_req;
  logic                        pend_now;
  logic                        take_load;
  logic                        take_start;
  logic                        load_to_exec;
  logic [OUTPUT_NODES_NUM-1:0] done_vec;

  assign clear_req    = clear_cgra_config_i | clear_cgra_state_i;
  assign any_req      = clear_req | load_configuration_i | start_execution_i;
  // A start landing in the same cycle as cfg_done still counts as pending.
  assign pend_now     = pending | start_execution_i;
  assign take_load    = !abort_i && (state == ST_IDLE) && !clear_req && load_configuration_i;
  assign take_start   = !abort_i && (state == ST_IDLE) && !clear_req && !load_configuration_i
                        && start_execution_i;
  assign load_to_exec = !abort_i && (state == ST_LOAD_CFG) && cfg_done_i && pend_now;
  assign done_vec     = collected | (out_done_i & mask);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= ST_IDLE;
      pending             <= 1'b0;
      mask                <= '0;
      collected           <= '0;
      clr_cnt             <= '0;
      cfg_start_o         <= 1'b0;
      stream_start_o      <= 1'b0;
      flush_o             <= 1'b0;
      cgra_en_o           <= 1'b0;
      cgra_clear_config_o <= 1'b0;
      cgra_clear_state_o  <= 1'b0;
      busy_o              <= 1'b0;
      done_config_o       <= 1'b0;
      done_exec_o         <= 1'b0;
      error_o             <= 1'b0;
      irq_o               <= 1'b0;
    end else begin
      cfg_start_o    <= 1'b0;
      stream_start_o <= 1'b0;
      flush_o        <= 1'b0;
      irq_o          <= 1'b0;
      if (abort_i) begin
        state               <= ST_IDLE;
        busy_o              <= 1'b0;
        flush_o             <= 1'b1;
        cgra_en_o           <= 1'b0;
        cgra_clear_config_o <= 1'b0;
        cgra_clear_state_o  <= 1'b0;
        pending             <= 1'b0;
        done_config_o       <= 1'b0;
        done_exec_o         <= 1'b0;
        error_o             <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (clear_req) begin
              state               <= ST_CLEAR;
              busy_o              <= 1'b1;
              clr_cnt             <= '0;
              cgra_clear_config_o <= clear_cgra_config_i;
              cgra_clear_state_o  <= clear_cgra_state_i;
              if (clear_cgra_config_i) done_config_o <= 1'b0;
              if (load_configuration_i || start_execution_i) error_o <= 1'b1;
            end else if (load_configuration_i) begin
              state         <= ST_LOAD_CFG;
              busy_o        <= 1'b1;
              cfg_start_o   <= 1'b1;
              done_config_o <= 1'b0;
              pending       <= 1'b0;
              if (start_execution_i) error_o <= 1'b1;
            end else if (start_execution_i) begin
              state          <= ST_EXEC;
              busy_o         <= 1'b1;
              mask           <= out_active_i;
              collected      <= '0;
              cgra_en_o      <= 1'b1;
              stream_start_o <= 1'b1;
              done_exec_o    <= 1'b0;
            end
          end

          ST_CLEAR: begin
            if (any_req) error_o <= 1'b1;
            if (clr_cnt == CLR_LAST) begin
              state               <= ST_IDLE;
              busy_o              <= 1'b0;
              cgra_clear_config_o <= 1'b0;
              cgra_clear_state_o  <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end

          ST_LOAD_CFG: begin
            if (clear_req || load_configuration_i || (start_execution_i && pending)) begin
              error_o <= 1'b1;
            end
            if (start_execution_i && !pending) begin
              pending <= 1'b1;
              mask    <= out_active_i;
            end
            if (cfg_done_i) begin
              done_config_o <= 1'b1;
              irq_o         <= 1'b1;
              pending       <= 1'b0;
              if (pend_now) begin
                state          <= ST_EXEC;
                collected      <= '0;
                cgra_en_o      <= 1'b1;
                stream_start_o <= 1'b1;
                done_exec_o    <= 1'b0;
              end else begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
              end
            end
          end

          ST_EXEC: begin
            if (any_req) error_o <= 1'b1;
            if (done_vec == mask) begin
              state       <= ST_IDLE;
              busy_o      <= 1'b0;
              cgra_en_o   <= 1'b0;
              done_exec_o <= 1'b1;
              irq_o       <= 1'b1;
            end else begin
              collected <= done_vec;
            end
          end

          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

  // Counters freeze during an abort cycle and restart when their phase is entered.
  strela_sat_counter #(.WIDTH(CNT_W)) u_cnt_load (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (take_load),
    .enable (!abort_i && (state == ST_LOAD_CFG)),
    .count  (cycle_count_load_config_o)
  );

  strela_sat_counter #(.WIDTH(CNT_W)) u_cnt_exec (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (take_start || load_to_exec),
    .enable (!abort_i && (state == ST_EXEC)),
    .count  (cycle_count_execute_o)
  );

  strela_sat_counter #(.WIDTH(CNT_W)) u_cnt_stall (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (take_start || load_to_exec),
    .enable (!abort_i && (state == ST_EXEC) && stall_i),
    .count  (cycle_count_stall_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_strela_exec_ctrl.sv
`default_nettype none
// ============================================================================
// tb_strela_exec_ctrl - directed scenario bench for the STRELA exec controller
// Revision: 1.0
// ============================================================================
module tb_strela_exec_ctrl;

  localparam int N  = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0, start = 1'b0, clr_cfg = 1'b0, clr_st = 1'b0, abort = 1'b0;
  logic [N-1:0]  out_active = '0, out_done = '0;
  logic          cfg_done = 1'b0, stall = 1'b0;
  logic          cfg_start, stream_start, flush, cgra_en, cgra_clr_cfg, cgra_clr_st;
  logic          busy, done_config, done_exec, error, irq;
  logic [CW-1:0] cnt_load, cnt_exec, cnt_stall;

  int total = 0;
  int passed = 0;
  int irq_cnt = 0;
  int ss_cnt = 0;

  strela_exec_ctrl #(.OUTPUT_NODES_NUM(N), .CLEAR_CYCLES(2), .CNT_W(CW)) dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_n),
    .load_configuration_i      (load),
    .start_execution_i         (start),
    .clear_cgra_config_i       (clr_cfg),
    .clear_cgra_state_i        (clr_st),
    .abort_i                   (abort),
    .out_active_i              (out_active),
    .cfg_done_i                (cfg_done),
    .out_done_i                (out_done),
    .stall_i                   (stall),
    .cfg_start_o               (cfg_start),
    .stream_start_o            (stream_start),
    .flush_o                   (flush),
    .cgra_en_o                 (cgra_en),
    .cgra_clear_config_o       (cgra_clr_cfg),
    .cgra_clear_state_o        (cgra_clr_st),
    .busy_o                    (busy),
    .done_config_o             (done_config),
    .done_exec_o               (done_exec),
    .error_o                   (error),
    .irq_o                     (irq),
    .cycle_count_load_config_o (cnt_load),
    .cycle_count_execute_o     (cnt_exec),
    .cycle_count_stall_o       (cnt_stall)
  );

  always #5 clk = ~clk;

  // Pulse counters sample mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (irq === 1'b1) irq_cnt++;
    if (stream_start === 1'b1) ss_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
    total++; if ({cfg_start, stream_start, flush, cgra_en, cgra_clr_cfg, cgra_clr_st} !== 6'b0)
      $display("FAIL rst_pulses: got %b want 000000", {cfg_start, stream_start, flush, cgra_en, cgra_clr_cfg, cgra_clr_st}); else passed++;
    total++; if ({done_config, done_exec, error, irq} !== 4'b0)
      $display("FAIL rst_flags: got %b want 0000", {done_config, done_exec, error, irq}); else passed++;
    total++; if ({cnt_load, cnt_exec, cnt_stall} !== '0)
      $display("FAIL rst_counters: got %0d %0d %0d want 0 0 0", cnt_load, cnt_exec, cnt_stall); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL rst_idle: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_load_then_start();
    int base;
    base = irq_cnt;
    out_active = 4'b0001;
    load = 1'b1; tick(); load = 1'b0;
    total++; if ({cfg_start, busy, done_config} !== 3'b110)
      $display("FAIL ld_first: got %b want 110", {cfg_start, busy, done_config}); else passed++;
    total++; if (cnt_load !== 32'd0) $display("FAIL ld_cnt_start: got %0d want 0", cnt_load); else passed++;
    repeat (4) tick();
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    total++; if (cnt_load !== 32'd5) $display("FAIL ld_count: got %0d want 5", cnt_load); else passed++;
    total++; if ({done_config, irq, busy, cfg_start} !== 4'b1100)
      $display("FAIL ld_done: got %b want 1100", {done_config, irq, busy, cfg_start}); else passed++;
    start = 1'b1; tick(); start = 1'b0;
    total++; if ({stream_start, cgra_en, busy} !== 3'b111)
      $display("FAIL ex_first: got %b want 111", {stream_start, cgra_en, busy}); else passed++;
    total++; if (cnt_exec !== 32'd0) $display("FAIL ex_cnt_start: got %0d want 0", cnt_exec); else passed++;
    tick(); stall = 1'b1;
    repeat (3) tick(); stall = 1'b0;
    repeat (5) tick();
    out_done = 4'b0001; tick(); out_done = 4'b0000;
    total++; if (cnt_exec !== 32'd10) $display("FAIL ex_count: got %0d want 10", cnt_exec); else passed++;
    total++; if (cnt_stall !== 32'd3) $display("FAIL ex_stall: got %0d want 3", cnt_stall); else passed++;
    total++; if ({done_exec, irq, cgra_en, busy, done_config} !== 5'b11001)
      $display("FAIL ex_done: got %b want 11001", {done_exec, irq, cgra_en, busy, done_config}); else passed++;
    tick();
    total++; if (irq_cnt - base !== 2) $display("FAIL irq_total: got %0d want 2", irq_cnt - base); else passed++;
  endtask

  task automatic test_pending_start();
    int base_ss;
    base_ss = ss_cnt;
    out_active = 4'b0010;
    load = 1'b1; tick(); load = 1'b0;
    start = 1'b1; tick();
    tick(); start = 1'b0;
    total++; if ({error, cgra_en, busy, stream_start} !== 4'b1010)
      $display("FAIL pend_err: got %b want 1010", {error, cgra_en, busy, stream_start}); else passed++;
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    total++; if ({cgra_en, stream_start, done_config, irq} !== 4'b1111)
      $display("FAIL pend_exec: got %b want 1111", {cgra_en, stream_start, done_config, irq}); else passed++;
    total++; if (cnt_load !== 32'd3) $display("FAIL pend_ldcnt: got %0d want 3", cnt_load); else passed++;
    out_done = 4'b0010; tick(); out_done = 4'b0000;
    total++; if ({done_exec, cgra_en} !== 2'b10)
      $display("FAIL pend_done: got %b want 10", {done_exec, cgra_en}); else passed++;
    tick();
    total++; if (ss_cnt - base_ss !== 1) $display("FAIL pend_ss: got %0d want 1", ss_cnt - base_ss); else passed++;
    abort = 1'b1; tick(); abort = 1'b0;
    total++; if ({flush, error, done_config, done_exec} !== 4'b1000)
      $display("FAIL pend_abort: got %b want 1000", {flush, error, done_config, done_exec}); else passed++;
  endtask

  task automatic test_mask_order();
    out_active = 4'b0101;
    start = 1'b1; tick(); start = 1'b0;
    out_done = 4'b0100; tick(); out_done = 4'b0000;
    total++; if ({cgra_en, done_exec} !== 2'b10)
      $display("FAIL mask_partial: got %b want 10", {cgra_en, done_exec}); else passed++;
    tick();
    total++; if ({cgra_en, busy} !== 2'b11) $display("FAIL mask_wait: got %b want 11", {cgra_en, busy}); else passed++;
    out_done = 4'b0001; tick(); out_done = 4'b0000;
    total++; if ({done_exec, cgra_en, irq} !== 3'b101)
      $display("FAIL mask_done: got %b want 101", {done_exec, cgra_en, irq}); else passed++;
    total++; if (cnt_exec !== 32'd3) $display("FAIL mask_cnt: got %0d want 3", cnt_exec); else passed++;
    out_active = 4'b0000;
    start = 1'b1; tick(); start = 1'b0;
    total++; if ({cgra_en, stream_start, done_exec} !== 3'b110)
      $display("FAIL m0_first: got %b want 110", {cgra_en, stream_start, done_exec}); else passed++;
    tick();
    total++; if ({cgra_en, done_exec, busy} !== 3'b010)
      $display("FAIL m0_done: got %b want 010", {cgra_en, done_exec, busy}); else passed++;
    total++; if (cnt_exec !== 32'd1) $display("FAIL m0_cnt: got %0d want 1", cnt_exec); else passed++;
  endtask

  task automatic test_clear();
    load = 1'b1; tick(); load = 1'b0;
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    total++; if ({done_config, busy} !== 2'b10) $display("FAIL clr_pre: got %b want 10", {done_config, busy}); else passed++;
    total++; if (cnt_load !== 32'd1) $display("FAIL clr_ldcnt: got %0d want 1", cnt_load); else passed++;
    clr_cfg = 1'b1; clr_st = 1'b1; tick(); clr_cfg = 1'b0; clr_st = 1'b0;
    total++; if ({cgra_clr_cfg, cgra_clr_st, done_config, busy} !== 4'b1101)
      $display("FAIL clr_c1: got %b want 1101", {cgra_clr_cfg, cgra_clr_st, done_config, busy}); else passed++;
    load = 1'b1; tick(); load = 1'b0;
    total++; if ({cgra_clr_cfg, cgra_clr_st, error} !== 3'b111)
      $display("FAIL clr_c2: got %b want 111", {cgra_clr_cfg, cgra_clr_st, error}); else passed++;
    tick();
    total++; if ({cgra_clr_cfg, cgra_clr_st, busy, error, cfg_start} !== 5'b00010)
      $display("FAIL clr_end: got %b want 00010", {cgra_clr_cfg, cgra_clr_st, busy, error, cfg_start}); else passed++;
  endtask

  task automatic test_abort();
    abort = 1'b1; tick(); abort = 1'b0;
    total++; if (error !== 1'b0) $display("FAIL ab_errclr: got %0b want 0", error); else passed++;
    out_active = 4'b0001;
    start = 1'b1; tick(); start = 1'b0;
    stall = 1'b1;
    repeat (3) tick();
    total++; if ({cnt_exec, cnt_stall} !== {32'd3, 32'd3})
      $display("FAIL ab_pre: got %0d %0d want 3 3", cnt_exec, cnt_stall); else passed++;
    abort = 1'b1; tick(); abort = 1'b0;
    total++; if ({busy, flush, cgra_en, error, done_exec} !== 5'b01000)
      $display("FAIL ab_state: got %b want 01000", {busy, flush, cgra_en, error, done_exec}); else passed++;
    total++; if ({cnt_exec, cnt_stall} !== {32'd3, 32'd3})
      $display("FAIL ab_frozen: got %0d %0d want 3 3", cnt_exec, cnt_stall); else passed++;
    tick(); stall = 1'b0;
    total++; if ({flush, cnt_exec, cnt_stall} !== {1'b0, 32'd3, 32'd3})
      $display("FAIL ab_after: got %0b %0d %0d want 0 3 3", flush, cnt_exec, cnt_stall); else passed++;
  endtask

  task automatic test_async_reset();
    load = 1'b1; tick(); load = 1'b0;
    tick();
    total++; if ({busy, cnt_load} !== {1'b1, 32'd1})
      $display("FAIL ar_pre: got %0b %0d want 1 1", busy, cnt_load); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, cfg_start, cgra_en, irq, done_config} !== 5'b0)
      $display("FAIL ar_outs: got %b want 00000", {busy, cfg_start, cgra_en, irq, done_config}); else passed++;
    total++; if ({cnt_load, cnt_exec, cnt_stall} !== '0)
      $display("FAIL ar_counters: got %0d %0d %0d want 0 0 0", cnt_load, cnt_exec, cnt_stall); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL ar_idle: got %0b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_then_start();
    test_pending_start();
    test_mask_order();
    test_clear();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
